// File: rtl/mul31_column_compressor_pkg.sv
// Shared constants and elaboration-time helpers for the 31x31 bit-heap compressor.
// stage_info() replays the Dadda schedule so every generate block knows its own counter counts.
package mul31_pkg;

  localparam int N         = 31;
  localparam int NCOL      = 2 * N - 1;
  localparam int NOUT      = 2 * N + 1;
  localparam int HEAP_BITS = N * N;
  localparam int MAXH      = N;
  localparam int NSTAGE    = 8;
  localparam logic [NOUT-1:0] MAX_RESULT = 63'h3FFF_FFFF_0000_0001;

  function automatic int col_height(int i);
    if (i < 0 || i >= NCOL) return 0;
    return (i + 1 < 2 * N - 1 - i) ? i + 1 : 2 * N - 1 - i;
  endfunction

  function automatic int col_offset(int i);
    int off = 0;
    for (int k = 0; k < i; k++) off += col_height(k);
    return off;
  endfunction

  // Dadda height targets, largest first: 28,19,13,9,6,4,3,2.
  function automatic int dadda_target(int s);
    if (s == 0) return 28;
    if (s == 1) return 19;
    if (s == 2) return 13;
    if (s == 3) return 9;
    if (s == 4) return 6;
    if (s == 5) return 4;
    if (s == 6) return 3;
    return 2;
  endfunction

  // sel 0: column height entering stage s, 1: full adders used there, 2: half adders used there.
  function automatic int stage_info(int s, int i, int sel);
    int h [NOUT];
    int cin, excess, nfa, nha, hi, fa_i, ha_i;
    hi = 0; fa_i = 0; ha_i = 0;
    for (int c = 0; c < NOUT; c++) h[c] = col_height(c);
    for (int st = 0; st <= s; st++) begin
      cin = 0;
      for (int c = 0; c < NOUT; c++) begin
        excess = h[c] + cin - dadda_target(st);
        if (excess < 0) excess = 0;
        nfa = excess / 2;
        nha = excess % 2;
        if (st == s && c == i) begin
          hi = h[c]; fa_i = nfa; ha_i = nha;
        end
        h[c] = h[c] - 2 * nfa - nha + cin;
        cin  = nfa + nha;
      end
    end
    if (sel == 1) return fa_i;
    if (sel == 2) return ha_i;
    return hi;
  endfunction

endpackage

// File: rtl/mul31_column_compressor_if.sv
// Bit-heap bundle: packed columns in (column 0 at the LSB end) and the registered sum out.
interface mul31_column_compressor_if;
  import mul31_pkg::*;

  logic [HEAP_BITS-1:0] heap;
  logic [NOUT-1:0]      sum;

  modport master (output heap, input sum);
  modport slave  (input heap, output sum);
endinterface

// File: rtl/mul31_column_compressor_core.sv
// Dadda reduction of the packed heap to two rows, final add, single output register.
module mul31_column_compressor_core
  import mul31_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  mul31_column_compressor_if.slave bus
);
  logic [MAXH-1:0] col [NSTAGE+1][NOUT];
  logic [MAXH-1:0] cy  [NSTAGE][NOUT];
  logic [NOUT-1:0] op_a, op_b, sum_next, sum_reg;

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_load
    localparam int H   = col_height(gi);
    localparam int OFF = col_offset(gi);
    for (genvar gb = 0; gb < MAXH; gb++) begin : g_bit
      if (gb < H) begin : g_src
        assign col[0][gi][gb] = bus.heap[OFF+gb];
      end else begin : g_zero
        assign col[0][gi][gb] = 1'b0;
      end
    end
  end

  // Next-stage column layout: FA sums, HA sums, untouched bits, then carries from column gi-1.
  for (genvar gs = 0; gs < NSTAGE; gs++) begin : g_stage
    for (genvar gi = 0; gi < NOUT; gi++) begin : g_col
      localparam int H     = stage_info(gs, gi, 0);
      localparam int NFA   = stage_info(gs, gi, 1);
      localparam int NHA   = stage_info(gs, gi, 2);
      localparam int CIN   = (gi == 0) ? 0 : stage_info(gs, gi - 1, 1) + stage_info(gs, gi - 1, 2);
      localparam int NCNT  = NFA + NHA;
      localparam int USED  = 3 * NFA + 2 * NHA;
      localparam int NPASS = H - USED;

      for (genvar gk = 0; gk < NFA; gk++) begin : g_fa
        full_adder_cell u_fa (
          .a    (col[gs][gi][3*gk]),
          .b    (col[gs][gi][3*gk+1]),
          .cin  (col[gs][gi][3*gk+2]),
          .s    (col[gs+1][gi][gk]),
          .cout (cy[gs][gi][gk])
        );
      end

      for (genvar gk = 0; gk < NHA; gk++) begin : g_ha
        localparam int B = 3 * NFA + 2 * gk;
        assign col[gs+1][gi][NFA+gk] = col[gs][gi][B] ^ col[gs][gi][B+1];
        assign cy[gs][gi][NFA+gk]    = col[gs][gi][B] & col[gs][gi][B+1];
      end

      for (genvar gb = NCNT; gb < MAXH; gb++) begin : g_rest
        assign cy[gs][gi][gb] = 1'b0;
        if (gb < NCNT + NPASS) begin : g_pass
          assign col[gs+1][gi][gb] = col[gs][gi][USED+gb-NCNT];
        end else if (gb < NCNT + NPASS + CIN) begin : g_carry
          assign col[gs+1][gi][gb] = cy[gs][gi-1][gb-NCNT-NPASS];
        end else begin : g_zero
          assign col[gs+1][gi][gb] = 1'b0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_rows
    assign op_a[gi] = col[NSTAGE][gi][0];
    assign op_b[gi] = col[NSTAGE][gi][1];
  end

  // Carry out of the top bit is dropped, giving the result modulo 2^63.
  assign sum_next = op_a + op_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_reg <= '0;
    else        sum_reg <= sum_next;
  end

  assign bus.sum = sum_reg;
endmodule

// File: rtl/mul31_column_compressor_full_adder_cell.sv
// 3:2 counter used as the building block of the reduction tree.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/mul31_column_compressor.sv
// Top level: flattens the 61 named heap columns into the bundle and fans the sum out to dst bits.
module mul31_column_compressor
  import mul31_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic [0:0]  src0,  input logic [1:0]  src1,  input logic [2:0]  src2,  input logic [3:0]  src3,
  input  logic [4:0]  src4,  input logic [5:0]  src5,  input logic [6:0]  src6,  input logic [7:0]  src7,
  input  logic [8:0]  src8,  input logic [9:0]  src9,  input logic [10:0] src10, input logic [11:0] src11,
  input  logic [12:0] src12, input logic [13:0] src13, input logic [14:0] src14, input logic [15:0] src15,
  input  logic [16:0] src16, input logic [17:0] src17, input logic [18:0] src18, input logic [19:0] src19,
  input  logic [20:0] src20, input logic [21:0] src21, input logic [22:0] src22, input logic [23:0] src23,
  input  logic [24:0] src24, input logic [25:0] src25, input logic [26:0] src26, input logic [27:0] src27,
  input  logic [28:0] src28, input logic [29:0] src29, input logic [30:0] src30, input logic [29:0] src31,
  input  logic [28:0] src32, input logic [27:0] src33, input logic [26:0] src34, input logic [25:0] src35,
  input  logic [24:0] src36, input logic [23:0] src37, input logic [22:0] src38, input logic [21:0] src39,
  input  logic [20:0] src40, input logic [19:0] src41, input logic [18:0] src42, input logic [17:0] src43,
  input  logic [16:0] src44, input logic [15:0] src45, input logic [14:0] src46, input logic [13:0] src47,
  input  logic [12:0] src48, input logic [11:0] src49, input logic [10:0] src50, input logic [9:0]  src51,
  input  logic [8:0]  src52, input logic [7:0]  src53, input logic [6:0]  src54, input logic [5:0]  src55,
  input  logic [4:0]  src56, input logic [3:0]  src57, input logic [2:0]  src58, input logic [1:0]  src59,
  input  logic [0:0]  src60,
  output logic dst0,  dst1,  dst2,  dst3,  dst4,  dst5,  dst6,  dst7,  dst8,  dst9,
               dst10, dst11, dst12, dst13, dst14, dst15, dst16, dst17, dst18, dst19,
               dst20, dst21, dst22, dst23, dst24, dst25, dst26, dst27, dst28, dst29,
               dst30, dst31, dst32, dst33, dst34, dst35, dst36, dst37, dst38, dst39,
               dst40, dst41, dst42, dst43, dst44, dst45, dst46, dst47, dst48, dst49,
               dst50, dst51, dst52, dst53, dst54, dst55, dst56, dst57, dst58, dst59,
               dst60, dst61, dst62
);
  mul31_column_compressor_if bus ();

  assign bus.heap = {src60, src59, src58, src57, src56, src55, src54, src53, src52, src51,
                     src50, src49, src48, src47, src46, src45, src44, src43, src42, src41,
                     src40, src39, src38, src37, src36, src35, src34, src33, src32, src31,
                     src30, src29, src28, src27, src26, src25, src24, src23, src22, src21,
                     src20, src19, src18, src17, src16, src15, src14, src13, src12, src11,
                     src10, src9,  src8,  src7,  src6,  src5,  src4,  src3,  src2,  src1, src0};

  mul31_column_compressor_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign {dst62, dst61, dst60, dst59, dst58, dst57, dst56, dst55, dst54, dst53,
          dst52, dst51, dst50, dst49, dst48, dst47, dst46, dst45, dst44, dst43,
          dst42, dst41, dst40, dst39, dst38, dst37, dst36, dst35, dst34, dst33,
          dst32, dst31, dst30, dst29, dst28, dst27, dst26, dst25, dst24, dst23,
          dst22, dst21, dst20, dst19, dst18, dst17, dst16, dst15, dst14, dst13,
          dst12, dst11, dst10, dst9,  dst8,  dst7,  dst6,  dst5,  dst4,  dst3,
          dst2,  dst1,  dst0} = bus.sum;
endmodule

// File: tb/tb_mul31_column_compressor.sv
// Directed bench for the 31x31 bit-heap compressor: fixed heaps, partial products, shuffles, reset.
module tb_mul31_column_compressor;
  localparam int N    = 31;
  localparam int NCOL = 61;
  localparam logic [63:0] MAX_S = 64'h3FFF_FFFF_0000_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [30:0] col [NCOL];
  logic [62:0] dst;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mul31_column_compressor dut (
    .clk(clk), .rst_n(rst_n),
    .src0(col[0][0:0]),   .src1(col[1][1:0]),   .src2(col[2][2:0]),   .src3(col[3][3:0]),
    .src4(col[4][4:0]),   .src5(col[5][5:0]),   .src6(col[6][6:0]),   .src7(col[7][7:0]),
    .src8(col[8][8:0]),   .src9(col[9][9:0]),   .src10(col[10][10:0]), .src11(col[11][11:0]),
    .src12(col[12][12:0]), .src13(col[13][13:0]), .src14(col[14][14:0]), .src15(col[15][15:0]),
    .src16(col[16][16:0]), .src17(col[17][17:0]), .src18(col[18][18:0]), .src19(col[19][19:0]),
    .src20(col[20][20:0]), .src21(col[21][21:0]), .src22(col[22][22:0]), .src23(col[23][23:0]),
    .src24(col[24][24:0]), .src25(col[25][25:0]), .src26(col[26][26:0]), .src27(col[27][27:0]),
    .src28(col[28][28:0]), .src29(col[29][29:0]), .src30(col[30][30:0]), .src31(col[31][29:0]),
    .src32(col[32][28:0]), .src33(col[33][27:0]), .src34(col[34][26:0]), .src35(col[35][25:0]),
    .src36(col[36][24:0]), .src37(col[37][23:0]), .src38(col[38][22:0]), .src39(col[39][21:0]),
    .src40(col[40][20:0]), .src41(col[41][19:0]), .src42(col[42][18:0]), .src43(col[43][17:0]),
    .src44(col[44][16:0]), .src45(col[45][15:0]), .src46(col[46][14:0]), .src47(col[47][13:0]),
    .src48(col[48][12:0]), .src49(col[49][11:0]), .src50(col[50][10:0]), .src51(col[51][9:0]),
    .src52(col[52][8:0]),  .src53(col[53][7:0]),  .src54(col[54][6:0]),  .src55(col[55][5:0]),
    .src56(col[56][4:0]),  .src57(col[57][3:0]),  .src58(col[58][2:0]),  .src59(col[59][1:0]),
    .src60(col[60][0:0]),
    .dst0(dst[0]),   .dst1(dst[1]),   .dst2(dst[2]),   .dst3(dst[3]),   .dst4(dst[4]),   .dst5(dst[5]),
    .dst6(dst[6]),   .dst7(dst[7]),   .dst8(dst[8]),   .dst9(dst[9]),   .dst10(dst[10]), .dst11(dst[11]),
    .dst12(dst[12]), .dst13(dst[13]), .dst14(dst[14]), .dst15(dst[15]), .dst16(dst[16]), .dst17(dst[17]),
    .dst18(dst[18]), .dst19(dst[19]), .dst20(dst[20]), .dst21(dst[21]), .dst22(dst[22]), .dst23(dst[23]),
    .dst24(dst[24]), .dst25(dst[25]), .dst26(dst[26]), .dst27(dst[27]), .dst28(dst[28]), .dst29(dst[29]),
    .dst30(dst[30]), .dst31(dst[31]), .dst32(dst[32]), .dst33(dst[33]), .dst34(dst[34]), .dst35(dst[35]),
    .dst36(dst[36]), .dst37(dst[37]), .dst38(dst[38]), .dst39(dst[39]), .dst40(dst[40]), .dst41(dst[41]),
    .dst42(dst[42]), .dst43(dst[43]), .dst44(dst[44]), .dst45(dst[45]), .dst46(dst[46]), .dst47(dst[47]),
    .dst48(dst[48]), .dst49(dst[49]), .dst50(dst[50]), .dst51(dst[51]), .dst52(dst[52]), .dst53(dst[53]),
    .dst54(dst[54]), .dst55(dst[55]), .dst56(dst[56]), .dst57(dst[57]), .dst58(dst[58]), .dst59(dst[59]),
    .dst60(dst[60]), .dst61(dst[61]), .dst62(dst[62])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int height(int i);
    return (i < N) ? i + 1 : NCOL - i;
  endfunction

  task automatic load_const(input logic bit_val);
    for (int i = 0; i < NCOL; i++) col[i] = bit_val ? 31'h7FFF_FFFF : 31'h0;
  endtask

  // srcI gets a[j] & b[I-j]; the slot inside the column starts at 0 for every column.
  task automatic load_pp(input logic [30:0] a, input logic [30:0] b);
    for (int i = 0; i < NCOL; i++) begin
      col[i] = '0;
      for (int j = 0; j < N; j++)
        if (i - j >= 0 && i - j < N) col[i][j - ((i > N - 1) ? i - (N - 1) : 0)] = a[j] & b[i-j];
    end
  endtask

  // Same popcount per column as load_pp, but the set bits land on random slots.
  task automatic load_shuffled(input logic [30:0] a, input logic [30:0] b);
    int pc, h, r, t;
    int p [31];
    for (int i = 0; i < NCOL; i++) begin
      pc = 0;
      for (int j = 0; j < N; j++)
        if (i - j >= 0 && i - j < N) pc += int'(a[j] & b[i-j]);
      h = height(i);
      for (int k = 0; k < h; k++) p[k] = k;
      for (int k = h - 1; k > 0; k--) begin
        r = int'($urandom_range(k, 0));
        t = p[k]; p[k] = p[r]; p[r] = t;
      end
      col[i] = '0;
      for (int k = 0; k < pc; k++) col[i][p[k]] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [30:0] va, vb;
  logic [63:0] exp_s;
  logic [30:0] ca [8];
  logic [30:0] cb [8];

  initial begin
    ca[0] = 31'd0;          cb[0] = 31'h5A5A_1234;
    ca[1] = 31'h7FFF_FFFF;  cb[1] = 31'd0;
    ca[2] = 31'd1;          cb[2] = 31'h6DB6_DB6D;
    ca[3] = 31'h4000_0001;  cb[3] = 31'd1;
    ca[4] = 31'h7FFF_FFFF;  cb[4] = 31'h7FFF_FFFF;
    ca[5] = 31'h4000_0000;  cb[5] = 31'h4000_0000;
    ca[6] = 31'd3;          cb[6] = 31'd5;
    ca[7] = 31'h1234_5678;  cb[7] = 31'h0765_4321;

    rst_n = 1'b0;
    load_const(1'b0);
    #1;
    check("reset_state", {1'b0, dst}, 64'd0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    step();
    check("zeros", {1'b0, dst}, 64'd0);
    $display("txn zeros dst=%h", dst);

    load_const(1'b1);
    step();
    check("all_ones", {1'b0, dst}, MAX_S);
    check("all_ones_dst62", {63'd0, dst[62]}, 64'd0);
    $display("txn all_ones dst=%h", dst);

    load_const(1'b0);
    col[30][0] = 1'b1;
    step();
    check("src30_bit0", {1'b0, dst}, 64'h4000_0000);
    check("src30_bit0_dst30", {63'd0, dst[30]}, 64'd1);
    $display("txn src30_bit0 dst=%h", dst);

    col[30] = 31'h7FFF_FFFF;
    step();
    check("src30_full", {1'b0, dst}, 64'h7_C000_0000);
    $display("txn src30_full dst=%h", dst);

    // Back-to-back: each vector is loaded right after the previous result is sampled.
    for (int k = 0; k < 8; k++) begin
      load_pp(ca[k], cb[k]);
      exp_s = 64'(ca[k]) * 64'(cb[k]);
      step();
      check("pp_corner", {1'b0, dst}, exp_s);
      $display("txn corner a=%h b=%h dst=%h", ca[k], cb[k], dst);
    end

    for (int k = 0; k < 1000; k++) begin
      va = 31'($urandom);
      vb = 31'($urandom);
      load_pp(va, vb);
      exp_s = 64'(va) * 64'(vb);
      step();
      check("pp_rand", {1'b0, dst}, exp_s);
      $display("txn rand %0d a=%h b=%h dst=%h", k, va, vb, dst);
    end

    for (int k = 0; k < 8; k++) begin
      va = (k < 4) ? ca[k+4] : 31'($urandom);
      vb = (k < 4) ? cb[k+4] : 31'($urandom);
      load_shuffled(va, vb);
      exp_s = 64'(va) * 64'(vb);
      step();
      check("shuffle", {1'b0, dst}, exp_s);
      $display("txn shuffle a=%h b=%h dst=%h", va, vb, dst);
    end

    load_const(1'b1);
    step();
    check("pre_reset", {1'b0, dst}, MAX_S);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {1'b0, dst}, 64'd0);
    step();
    check("rst_hold", {1'b0, dst}, 64'd0);
    #3 rst_n = 1'b1;
    #1;
    check("rst_release_pre_edge", {1'b0, dst}, 64'd0);
    step();
    check("rst_reload", {1'b0, dst}, MAX_S);
    $display("txn reset_reload dst=%h", dst);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
